vape_exec_ctrl: RTL and testbench
=================================

# vape_exec_ctrl

Sequencer and configuration owner for the VAPE execution-boundary monitor. It holds the ER and META region bounds and drives them to the monitor. It validates and locks the bounds for one attested run, tracks the run from first instruction to last, and reports DONE or FAULT with a cycle count. It sits between the software-visible config port and the boundary monitor, whose `exec` output it consumes.

## Interface
Parameters:
- CNT_W, 16: width of the run cycle counter.
- MAX_CYCLES, 16'hFFFF: run timeout in cycles; used only with the timeout feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted this cycle when high together with cfg_valid.
- cfg_sel  in  2  target register: 0 ER_MIN, 1 ER_MAX, 2 META_MIN, 3 META_MAX.
- cfg_data  in  16  write data.
- arm  in  1  single-cycle request to lock the config and wait for entry.
- clr  in  1  single-cycle request to return to CONFIG from DONE or FAULT.
- pc  in  16  current program counter.
- exec_in  in  1  exec flag from the boundary monitor.
- er_min, er_max, meta_min, meta_max  out  16 each  registered bounds, driven to the monitor.
- state_o  out  3  current state encoding.
- done  out  1  high while in DONE.
- fault  out  1  high while in FAULT.
- run_cycles  out  CNT_W  number of cycles spent in RUN.

## Operation
States: CONFIG(0), ARMED(1), RUN(2), DONE(3), FAULT(4).

Request priority: rst_n > clr > arm > cfg write.

- **CONFIG**
  - cfg_ready = !arm. A cfg write updates the selected register on the next edge.
  - arm samples the registers before any same-cycle write; no write happens in an arm cycle.
  - The config is valid when er_min <= er_max, meta_min <= meta_max, and the ranges are disjoint (meta_max < er_min or meta_min > er_max).
  - arm with a valid config goes to ARMED; arm with an invalid config goes to FAULT.
  - clr in CONFIG reloads the reset values of the bound registers.
- **ARMED**
  - cfg_ready = 0.
  - When pc == er_min, go to RUN and load run_cycles = 1.
  - clr goes to CONFIG.
- **RUN**
  - run_cycles increments each cycle and saturates at all-ones.
  - exec_in is ignored in the first RUN cycle, because the monitor has one cycle of latency. After that, exec_in == 0 goes to FAULT.
  - pc outside [er_min, er_max] goes to FAULT.
  - pc == er_max goes to DONE. This exit has priority over the exec_in check in the same cycle.
  - clr is ignored in RUN.
- **DONE / FAULT**
  - Hold state. run_cycles is frozen. clr goes to CONFIG with run_cycles = 0.

Bounds never change outside CONFIG.

## Timing
- All outputs are registered except cfg_ready, which is combinational from the state and arm.
- Reset values: state CONFIG, er_min 16'hFFFF, er_max 16'h0000, meta_min 16'hFFFF, meta_max 16'h0000 (invalid until configured), run_cycles 0, done 0, fault 0.
- Reset is honoured in any state, including mid-RUN. It discards the run and the bounds.
- arm to state_o == ARMED: 1 edge.
- pc == er_min to RUN: 1 edge.
- pc == er_max to done = 1: 1 edge.
- Violation to fault = 1: 1 edge.
- If er_min == er_max, entry and exit happen back to back: ARMED → RUN → DONE, with run_cycles = 1.

## Configuration
- `VAPE_EXEC_CTRL_TIMEOUT_EN` defined: in RUN, when run_cycles == MAX_CYCLES and the DONE exit condition is false, go to FAULT.
- Not defined: no timeout; run_cycles only saturates. MAX_CYCLES is unused.

## Structure
- Package vape_pkg holds:
  - the state enum type vape_state_t,
  - cfg_sel codes (VAPE_SEL_ER_MIN…VAPE_SEL_META_MAX),
  - reset constants for the bounds.
- Sub-module vape_region_check: combinational config-validity check (ordering plus disjointness). It takes four 16-bit inputs and produces one `valid` output, and is instantiated once.

## Test plan
- Write ER 0xE000–0xE0FF and META 0x0200–0x021F, arm, pc = 0xE000, then pc steps to 0xE0FF with exec_in = 1 from the second RUN cycle → DONE, done = 1, run_cycles equals the RUN cycle count.
- Arm with er_min 0xE100 > er_max 0xE000 → FAULT one edge after arm; bounds unchanged.
- Arm with META 0xE080–0xE090 overlapping ER 0xE000–0xE0FF → FAULT.
- In RUN, drop exec_in in the third cycle → FAULT; separately, pc = 0x4000 mid-RUN → FAULT.
- Assert arm and cfg_valid together → cfg_ready = 0, the register is not updated, and arm uses the old values. Assert clr from DONE → CONFIG with run_cycles = 0.
- With `VAPE_EXEC_CTRL_TIMEOUT_EN` and MAX_CYCLES = 8, hold pc inside ER without reaching er_max → FAULT when run_cycles = 8. Without the macro, no fault occurs. Apply rst_n = 0 mid-RUN → CONFIG with reset bounds.

Source files
------------

// File: rtl/vape_pkg.sv
// Shared types and constants for the VAPE execution controller: states, cfg_sel codes, bound reset values.
package vape_pkg;

  localparam int unsigned VAPE_ADDR_W = 16;

  typedef enum logic [2:0] {
    ST_CONFIG = 3'd0,
    ST_ARMED  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } vape_state_t;

  localparam logic [1:0] VAPE_SEL_ER_MIN   = 2'd0;
  localparam logic [1:0] VAPE_SEL_ER_MAX   = 2'd1;
  localparam logic [1:0] VAPE_SEL_META_MIN = 2'd2;
  localparam logic [1:0] VAPE_SEL_META_MAX = 2'd3;

  localparam logic [VAPE_ADDR_W-1:0] VAPE_RST_ER_MIN   = 16'hFFFF;
  localparam logic [VAPE_ADDR_W-1:0] VAPE_RST_ER_MAX   = 16'h0000;
  localparam logic [VAPE_ADDR_W-1:0] VAPE_RST_META_MIN = 16'hFFFF;
  localparam logic [VAPE_ADDR_W-1:0] VAPE_RST_META_MAX = 16'h0000;

  typedef struct packed {
    logic [VAPE_ADDR_W-1:0] er_min;
    logic [VAPE_ADDR_W-1:0] er_max;
    logic [VAPE_ADDR_W-1:0] meta_min;
    logic [VAPE_ADDR_W-1:0] meta_max;
  } vape_bounds_t;

  // Reset bounds are deliberately inverted so an unconfigured arm faults.
  localparam vape_bounds_t VAPE_BOUNDS_RST = '{
    er_min:   VAPE_RST_ER_MIN,
    er_max:   VAPE_RST_ER_MAX,
    meta_min: VAPE_RST_META_MIN,
    meta_max: VAPE_RST_META_MAX
  };

endpackage

// File: rtl/vape_exec_ctrl_if.sv
// Config, monitor and status signals between the VAPE execution controller and its surroundings.
interface vape_exec_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  import vape_pkg::*;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [1:0]             cfg_sel;
  logic [VAPE_ADDR_W-1:0] cfg_data;
  logic                   arm;
  logic                   clr;
  logic [VAPE_ADDR_W-1:0] pc;
  logic                   exec_in;
  logic [VAPE_ADDR_W-1:0] er_min;
  logic [VAPE_ADDR_W-1:0] er_max;
  logic [VAPE_ADDR_W-1:0] meta_min;
  logic [VAPE_ADDR_W-1:0] meta_max;
  logic [2:0]             state_o;
  logic                   done;
  logic                   fault;
  logic [CNT_W-1:0]       run_cycles;

  modport master (
    output cfg_valid, cfg_sel, cfg_data, arm, clr, pc, exec_in,
    input  cfg_ready, er_min, er_max, meta_min, meta_max, state_o, done, fault, run_cycles
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_data, arm, clr, pc, exec_in,
    output cfg_ready, er_min, er_max, meta_min, meta_max, state_o, done, fault, run_cycles
  );

endinterface

// File: rtl/vape_region_check.sv
// Config validity: both ranges ordered and the META range disjoint from the ER range.
module vape_region_check
  import vape_pkg::*;
(
  input  logic [VAPE_ADDR_W-1:0] er_min,
  input  logic [VAPE_ADDR_W-1:0] er_max,
  input  logic [VAPE_ADDR_W-1:0] meta_min,
  input  logic [VAPE_ADDR_W-1:0] meta_max,
  output logic                   valid
);

  assign valid = (er_min <= er_max) && (meta_min <= meta_max) &&
                 ((meta_max < er_min) || (meta_min > er_max));

endmodule

// File: rtl/vape_exec_ctrl.sv
// VAPE execution controller: owns the ER/META bounds, locks them for one run and reports DONE/FAULT.
// Optional run timeout enabled by defining VAPE_EXEC_CTRL_TIMEOUT_EN.
module vape_exec_ctrl
  import vape_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MAX_CYCLES = 32'h0000_FFFF
) (
  input logic             clk,
  input logic             rst_n,
  vape_exec_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  vape_state_t      state_q, state_n;
  vape_bounds_t     bnd_q, bnd_n;
  logic [CNT_W-1:0] rc_q, rc_n;
  logic             done_q, fault_q;
  logic             cfg_ok;
  logic             in_er;
  logic             first_cyc;
  logic             timeout;

  vape_region_check u_region_check (
    .er_min   (bnd_q.er_min),
    .er_max   (bnd_q.er_max),
    .meta_min (bnd_q.meta_min),
    .meta_max (bnd_q.meta_max),
    .valid    (cfg_ok)
  );

`ifdef VAPE_EXEC_CTRL_TIMEOUT_EN
  assign timeout = (rc_q == CNT_W'(MAX_CYCLES));
`else
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign timeout = 1'b0;
`endif

  assign in_er     = (bus.pc >= bnd_q.er_min) && (bus.pc <= bnd_q.er_max);
  // Counter reads 1 only in the first RUN cycle, while monitor output is still stale.
  assign first_cyc = (rc_q == CNT_ONE);

  assign bus.cfg_ready = (state_q == ST_CONFIG) && !bus.arm;

  // Next-state, bound and counter update.
  always_comb begin
    state_n = state_q;
    bnd_n   = bnd_q;
    rc_n    = rc_q;
    case (state_q)
      ST_CONFIG: begin
        if (bus.clr) begin
          bnd_n = VAPE_BOUNDS_RST;
        end else if (bus.arm) begin
          state_n = cfg_ok ? ST_ARMED : ST_FAULT;
        end else if (bus.cfg_valid) begin
          case (bus.cfg_sel)
            VAPE_SEL_ER_MIN:   bnd_n.er_min   = bus.cfg_data;
            VAPE_SEL_ER_MAX:   bnd_n.er_max   = bus.cfg_data;
            VAPE_SEL_META_MIN: bnd_n.meta_min = bus.cfg_data;
            VAPE_SEL_META_MAX: bnd_n.meta_max = bus.cfg_data;
          endcase
        end
      end
      ST_ARMED: begin
        if (bus.clr) begin
          state_n = ST_CONFIG;
        end else if (bus.pc == bnd_q.er_min) begin
          state_n = ST_RUN;
          rc_n    = CNT_ONE;
        end
      end
      ST_RUN: begin
        if (bus.pc == bnd_q.er_max) begin
          state_n = ST_DONE;
        end else if (!in_er) begin
          state_n = ST_FAULT;
        end else if (!first_cyc && !bus.exec_in) begin
          state_n = ST_FAULT;
        end else if (timeout) begin
          state_n = ST_FAULT;
        end else if (rc_q != CNT_SAT) begin
          rc_n = rc_q + CNT_ONE;
        end
      end
      ST_DONE, ST_FAULT: begin
        if (bus.clr) begin
          state_n = ST_CONFIG;
          rc_n    = '0;
        end
      end
      default: begin
        state_n = ST_CONFIG;
        rc_n    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_CONFIG;
      bnd_q   <= VAPE_BOUNDS_RST;
      rc_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      bnd_q   <= bnd_n;
      rc_q    <= rc_n;
      done_q  <= (state_n == ST_DONE);
      fault_q <= (state_n == ST_FAULT);
    end
  end

  assign bus.er_min     = bnd_q.er_min;
  assign bus.er_max     = bnd_q.er_max;
  assign bus.meta_min   = bnd_q.meta_min;
  assign bus.meta_max   = bnd_q.meta_max;
  assign bus.state_o    = state_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.run_cycles = rc_q;

endmodule

// File: tb/tb_vape_exec_ctrl.sv
// Self-checking bench for vape_exec_ctrl: directed scenarios plus randomized runs against a run-level model.
module tb_vape_exec_ctrl;
  import vape_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAX_C = 8;
  localparam int S_CONFIG = 0, S_ARMED = 1, S_RUN = 2, S_DONE = 3, S_FAULT = 4;
`ifdef VAPE_EXEC_CTRL_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  vape_exec_ctrl_if #(.CNT_W(CNT_W)) bus ();

  vape_exec_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(MAX_C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Model of the software-visible bound registers.
  logic [15:0] m_er_min, m_er_max, m_meta_min, m_meta_max;
  logic [15:0] pcs [0:31];
  bit          exs [0:31];
  bit          cls [0:31];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit cfg_ok();
    return (m_er_min <= m_er_max) && (m_meta_min <= m_meta_max) &&
           ((m_meta_max < m_er_min) || (m_meta_min > m_er_max));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset_bounds();
    m_er_min = 16'hFFFF; m_er_max = 16'h0000;
    m_meta_min = 16'hFFFF; m_meta_max = 16'h0000;
  endtask

  task automatic chk_bounds(input string tag);
    chk({tag, "_er_min"}, 32'(bus.er_min), 32'(m_er_min));
    chk({tag, "_er_max"}, 32'(bus.er_max), 32'(m_er_max));
    chk({tag, "_meta_min"}, 32'(bus.meta_min), 32'(m_meta_min));
    chk({tag, "_meta_max"}, 32'(bus.meta_max), 32'(m_meta_max));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(bus.state_o), S_CONFIG);
    chk({tag, "_rc"}, 32'(bus.run_cycles), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_fault"}, 32'(bus.fault), 0);
    chk_bounds(tag);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    model_reset_bounds();
  endtask

  task automatic write_cfg(input logic [1:0] sel, input logic [15:0] data);
    bus.cfg_valid = 1'b1; bus.cfg_sel = sel; bus.cfg_data = data;
    tick();
    bus.cfg_valid = 1'b0;
    case (sel)
      2'd0: m_er_min = data;
      2'd1: m_er_max = data;
      2'd2: m_meta_min = data;
      default: m_meta_max = data;
    endcase
  endtask

  task automatic set_cfg(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    write_cfg(2'd0, a); write_cfg(2'd1, b); write_cfg(2'd2, c); write_cfg(2'd3, d);
  endtask

  task automatic arm_and_check(input string tag, output int st);
    chk({tag, "_ready_cfg"}, 32'(bus.cfg_ready), 1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    st = cfg_ok() ? S_ARMED : S_FAULT;
    chk({tag, "_arm_state"}, 32'(bus.state_o), st);
    chk({tag, "_arm_fault"}, 32'(bus.fault), (st == S_FAULT) ? 1 : 0);
    chk({tag, "_arm_ready"}, 32'(bus.cfg_ready), 0);
    chk_bounds({tag, "_arm"});
  endtask

  task automatic clr_and_check(input string tag, input bit from_config);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    if (from_config) model_reset_bounds();
    chk_reset({tag, "_clr"});
  endtask

  // Walks one run: entry at er_min, then n RUN cycles from pcs/exs/cls; returns the final state.
  task automatic run_seq(input string tag, input int n, output int fs);
    int nxt;
    bus.exec_in = 1'b0;
    bus.pc = m_er_min - 16'd1;
    tick();
    chk({tag, "_wait"}, 32'(bus.state_o), S_ARMED);
    bus.pc = m_er_min;
    tick();
    chk({tag, "_entry"}, 32'(bus.state_o), S_RUN);
    chk({tag, "_entry_rc"}, 32'(bus.run_cycles), 1);
    fs = S_RUN;
    for (int k = 1; k <= n; k++) begin
      if (pcs[k-1] == m_er_max) nxt = S_DONE;
      else if (pcs[k-1] < m_er_min || pcs[k-1] > m_er_max) nxt = S_FAULT;
      else if (k > 1 && !exs[k-1]) nxt = S_FAULT;
      else if (TMO && k == int'(MAX_C)) nxt = S_FAULT;
      else nxt = S_RUN;
      bus.pc = pcs[k-1]; bus.exec_in = exs[k-1]; bus.clr = cls[k-1];
      tick();
      bus.clr = 1'b0;
      chk($sformatf("%s_c%0d_state", tag, k), 32'(bus.state_o), nxt);
      chk($sformatf("%s_c%0d_rc", tag, k), 32'(bus.run_cycles), (nxt == S_RUN) ? k + 1 : k);
      if (nxt != S_RUN) begin
        chk({tag, "_done"}, 32'(bus.done), (nxt == S_DONE) ? 1 : 0);
        chk({tag, "_fault"}, 32'(bus.fault), (nxt == S_FAULT) ? 1 : 0);
        bus.pc = 16'($urandom); bus.exec_in = 1'($urandom);
        tick();
        chk({tag, "_hold_state"}, 32'(bus.state_o), nxt);
        chk({tag, "_hold_rc"}, 32'(bus.run_cycles), k);
        fs = nxt;
        break;
      end
    end
    chk_bounds({tag, "_run"});
  endtask

  task automatic finish_run(input string tag, input int fs);
    if (fs == S_RUN) begin
      reset_dut();
      chk_reset({tag, "_rst"});
    end else begin
      clr_and_check(tag, 1'b0);
    end
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 32; i++) begin
      pcs[i] = 16'h0; exs[i] = 1'b1; cls[i] = 1'b0;
    end
  endtask

  initial begin
    int st, fs, n, r;
    logic [15:0] emin, len, mmin;
    rst_n = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_data = 16'h0;
    bus.arm = 1'b0; bus.clr = 1'b0; bus.pc = 16'h0; bus.exec_in = 1'b0;
    reset_dut();
    chk_reset("por");
    chk("por_ready", 32'(bus.cfg_ready), 1);

    // Nominal run with exec low in the first RUN cycle (ignored).
    set_cfg(16'hE000, 16'hE0FF, 16'h0200, 16'h021F);
    chk_bounds("cfg");
    arm_and_check("nom", st);
    clear_seq();
    pcs[0] = 16'hE000; exs[0] = 1'b0;
    for (int i = 1; i < 16; i++) pcs[i] = 16'hE000 + 16'(i * 16);
    pcs[16] = 16'hE0FF;
    run_seq("nom", 17, fs);
    chk("nom_final", 32'(fs), S_DONE);
    finish_run("nom", fs);

    // Inverted ER and overlapping META both fault on arm.
    set_cfg(16'hE100, 16'hE000, 16'h0200, 16'h021F);
    arm_and_check("inv", st);
    clr_and_check("inv", 1'b0);
    set_cfg(16'hE000, 16'hE0FF, 16'hE080, 16'hE090);
    arm_and_check("ovl", st);
    clr_and_check("ovl", 1'b0);

    // exec dropped in the third RUN cycle; pc escapes mid-run.
    set_cfg(16'hE000, 16'hE0FF, 16'h0200, 16'h021F);
    arm_and_check("exd", st);
    clear_seq();
    pcs[0] = 16'hE000; pcs[1] = 16'hE001; pcs[2] = 16'hE002; exs[2] = 1'b0;
    run_seq("exd", 3, fs);
    finish_run("exd", fs);
    arm_and_check("esc", st);
    clear_seq();
    pcs[0] = 16'hE000; pcs[1] = 16'h4000;
    run_seq("esc", 2, fs);
    finish_run("esc", fs);

    // arm wins over a same-cycle write and samples the old bounds.
    chk("race_ready_idle", 32'(bus.cfg_ready), 1);
    bus.arm = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_data = 16'hFFFF;
    #1;
    chk("race_ready", 32'(bus.cfg_ready), 0);
    tick();
    bus.arm = 1'b0; bus.cfg_valid = 1'b0;
    chk("race_state", 32'(bus.state_o), S_ARMED);
    chk_bounds("race");
    clr_and_check("armed", 1'b0);

    // Zero-length ER: entry and exit back to back.
    set_cfg(16'h3000, 16'h3000, 16'h0000, 16'h00FF);
    arm_and_check("pt", st);
    clear_seq();
    pcs[0] = 16'h3000;
    run_seq("pt", 1, fs);
    finish_run("pt", fs);

    // Long in-range hold, clr ignored in RUN; timeout or reset mid-run.
    set_cfg(16'h5000, 16'h50FF, 16'h0100, 16'h01FF);
    arm_and_check("hold", st);
    clear_seq();
    for (int i = 0; i < 12; i++) pcs[i] = 16'h5010;
    cls[1] = 1'b1; cls[2] = 1'b1;
    run_seq("hold", 12, fs);
    chk("hold_final", 32'(fs), TMO ? S_FAULT : S_RUN);
    finish_run("hold", fs);

    // clr in CONFIG reloads reset bounds.
    set_cfg(16'h1234, 16'h2345, 16'h0010, 16'h0020);
    clr_and_check("cfgclr", 1'b1);

    for (int it = 0; it < 30; it++) begin
      emin = 16'($urandom_range(16'h1000, 16'hF000));
      len  = 16'($urandom_range(0, 16'h40));
      r    = $urandom_range(0, 3);
      mmin = 16'($urandom_range(0, 16'h0800));
      case (r)
        0: set_cfg(emin, emin + len, emin, emin + 16'd2);
        1: set_cfg(emin, emin - 16'd1, mmin, mmin + 16'h10);
        default: set_cfg(emin, emin + len, mmin, mmin + 16'($urandom_range(0, 16'h100)));
      endcase
      arm_and_check($sformatf("rnd%0d", it), st);
      if (st == S_FAULT) begin
        clr_and_check($sformatf("rnd%0d", it), 1'b0);
      end else begin
        clear_seq();
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
          r = $urandom_range(0, 19);
          if (r == 0) pcs[i] = m_er_min - 16'd1;
          else if (r == 1) pcs[i] = m_er_max;
          else pcs[i] = m_er_min + 16'($urandom_range(0, int'(len)));
          exs[i] = ($urandom_range(0, 14) != 0);
        end
        run_seq($sformatf("rnd%0d", it), n, fs);
        finish_run($sformatf("rnd%0d", it), fs);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
